// File: rtl/fsm_serial_stimulus_tx.sv
// Serializes a parallel word MSB-first onto x_out with framing strobes and an idle gap.
// Optional even-parity bit after bit 0 when SERIAL_PARITY_EN is defined.
module fsm_serial_stimulus_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             x_out,
  output logic             busy,
  output logic             frame_start,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StShift  = 2'd1;
  localparam logic [1:0] StGap    = 2'd3;
`ifdef SERIAL_PARITY_EN
  localparam logic [1:0] StParity = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [3:0]       gapcnt_q, gapcnt_d;
  logic             ready_q, ready_d;
  logic             x_q, x_d;
  logic             busy_q, busy_d;
  logic             fs_q, fs_d;
  logic             done_q, done_d;
  logic             frame_end;
`ifdef SERIAL_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    gapcnt_d  = gapcnt_q;
    ready_d   = ready_q;
    x_d       = x_q;
    busy_d    = busy_q;
    fs_d      = fs_q;
    done_d    = done_q;
    frame_end = 1'b0;
`ifdef SERIAL_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      StIdle: begin
        if (load && ready_q) begin
          shreg_d  = data_in[WIDTH-2:0];
          x_d      = data_in[WIDTH-1];
          fs_d     = 1'b1;
          done_d   = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          bitcnt_d = CW'(WIDTH - 1);
          state_d  = StShift;
`ifdef SERIAL_PARITY_EN
          parity_d = ^data_in;
`endif
        end else begin
          // First edge after reset release raises ready here.
          ready_d = 1'b1;
        end
      end

      StShift: begin
        fs_d = 1'b0;
        if (bitcnt_q != '0) begin
          x_d      = shreg_q[WIDTH-2];
          shreg_d  = shreg_q << 1;
          bitcnt_d = bitcnt_q - CW'(1);
`ifndef SERIAL_PARITY_EN
          done_d   = (bitcnt_q == CW'(1));
`endif
        end else begin
`ifdef SERIAL_PARITY_EN
          x_d     = parity_q;
          done_d  = 1'b1;
          state_d = StParity;
`else
          frame_end = 1'b1;
`endif
        end
      end

`ifdef SERIAL_PARITY_EN
      StParity: frame_end = 1'b1;
`endif

      StGap: begin
        if (gapcnt_q == 4'd0) begin
          state_d = StIdle;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          gapcnt_d = gapcnt_q - 4'd1;
        end
      end

      default: state_d = StIdle;
    endcase

    if (frame_end) begin
      done_d = 1'b0;
      x_d    = 1'b0;
      if (GAP > 0) begin
        state_d  = StGap;
        gapcnt_d = 4'(GAP - 1);
      end else begin
        state_d = StIdle;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      ready_q  <= 1'b0;
      x_q      <= 1'b0;
      busy_q   <= 1'b0;
      fs_q     <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      ready_q  <= ready_d;
      x_q      <= x_d;
      busy_q   <= busy_d;
      fs_q     <= fs_d;
      done_q   <= done_d;
`ifdef SERIAL_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign ready       = ready_q;
  assign x_out       = x_q;
  assign busy        = busy_q;
  assign frame_start = fs_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fsm_serial_stimulus_tx.sv
// Self-checking bench for fsm_serial_stimulus_tx: word-table vectors, directed corner
// sequences and random traffic against a queue-based frame model.
module tb_fsm_serial_stimulus_tx;

  localparam int W = 8;
  localparam int G = 2;
`ifdef SERIAL_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int PERIOD = W + P + G + 1;

  logic         CLK = 1'b0;
  logic         Reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         ready, x_out, busy, frame_start, done;

  fsm_serial_stimulus_tx #(.WIDTH(W), .GAP(G)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .load       (load),
    .data_in    (data_in),
    .ready      (ready),
    .x_out      (x_out),
    .busy       (busy),
    .frame_start(frame_start),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Model: each queued entry is one busy cycle as seen on the outputs.
  typedef struct packed {logic x; logic fs; logic dn;} ent_t;
  ent_t q[$];
  bit   ready_m = 1'b0;

  typedef struct {logic [W-1:0] data; logic par;} vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  function automatic logic [4:0] model_out();
    logic [4:0] v;
    if (q.size() > 0) v = {1'b0, q[0].x, 1'b1, q[0].fs, q[0].dn};
    else              v = {ready_m, 4'b0000};
    return v;
  endfunction

  task automatic model_edge();
    ent_t e;
    if (!Reset) begin
      q.delete();
      ready_m = 1'b0;
      return;
    end
    if (q.size() > 0) begin
      void'(q.pop_front());
    end else if (ready_m && load) begin
      for (int i = 0; i < W; i++) begin
        e.x = data_in[W-1-i]; e.fs = (i == 0); e.dn = (P == 0) && (i == W - 1);
        q.push_back(e);
      end
      if (P == 1) begin
        e.x = ^data_in; e.fs = 1'b0; e.dn = 1'b1;
        q.push_back(e);
      end
      for (int i = 0; i < G; i++) begin
        e = '0;
        q.push_back(e);
      end
    end
    ready_m = 1'b1;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check("model", {ready, x_out, busy, frame_start, done}, model_out());
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 40 && !ready; i++) tick();
    check("ready_timeout", {4'b0, ready}, 5'b00001);
  endtask

  initial begin
    tbl[0] = '{8'b1011_0010, 1'b0};
    tbl[1] = '{8'b1011_0011, 1'b1};
    tbl[2] = '{8'h00, 1'b0};
    tbl[3] = '{8'hA5, 1'b0};
    tbl[4] = '{8'hFF, 1'b0};
    tbl[5] = '{8'h01, 1'b1};
    tbl[6] = '{8'h80, 1'b1};
    tbl[7] = '{8'h7E, 1'b0};

    // Reset held for 3 cycles, outputs all zero.
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", {ready, x_out, busy, frame_start, done}, 5'b00000);
    end
    Reset = 1'b1;
    tick();
    check("ready_after_release", {ready, x_out, busy, frame_start, done}, 5'b10000);

    // Word table; a load pulse in the 3rd bit cycle must be ignored.
    foreach (tbl[k]) begin
      wait_ready();
      load = 1'b1;
      data_in = tbl[k].data;
      tick();
      load = 1'b0;
      data_in = ~tbl[k].data;
      for (int i = 0; i < W + P; i++) begin
        logic b;
        b = (i < W) ? tbl[k].data[W-1-i] : tbl[k].par;
        check("tbl_bit", {ready, x_out, busy, frame_start, done},
              {1'b0, b, 1'b1, i == 0, i == W + P - 1});
        if (i == 2) begin
          load = 1'b1;
          data_in = 8'hFF;
        end
        tick();
        load = 1'b0;
      end
      for (int i = 0; i < G; i++) begin
        check("tbl_gap", {ready, x_out, busy, frame_start, done}, 5'b00100);
        tick();
      end
      check("tbl_idle", {ready, x_out, busy, frame_start, done}, 5'b10000);
    end

    // Back-to-back with load held high.
    begin
      int starts[$];
      wait_ready();
      load = 1'b1;
      data_in = 8'hA5;
      for (int t = 0; t < 3 * PERIOD + 2; t++) begin
        tick();
        if (frame_start) starts.push_back(t);
      end
      load = 1'b0;
      check("b2b_frames", {4'b0, starts.size() >= 3}, 5'b00001);
      for (int i = 1; i < starts.size(); i++)
        check("b2b_period", 5'(starts[i] - starts[i-1]), 5'(PERIOD));
    end

    // Asynchronous reset at the 5th bit of 8'hC3.
    wait_ready();
    load = 1'b1;
    data_in = 8'hC3;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("c3_bit5", {ready, x_out, busy, frame_start, done}, 5'b00100);
    #2 Reset = 1'b0;
    #1 check("async_reset", {ready, x_out, busy, frame_start, done}, 5'b00000);
    q.delete();
    ready_m = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    check("ready_after_abort", {ready, x_out, busy, frame_start, done}, 5'b10000);
    load = 1'b1;
    data_in = 8'h81;
    tick();
    load = 1'b0;
    check("h81_msb", {ready, x_out, busy, frame_start, done}, 5'b01110);
    for (int i = 1; i < W + P + G + 1; i++) tick();
    check("h81_drained", {ready, x_out, busy, frame_start, done}, 5'b10000);

    // Random traffic with occasional reset.
    for (int t = 0; t < 600; t++) begin
      load = ($urandom_range(0, 2) != 0);
      data_in = W'($urandom());
      Reset = ($urandom_range(0, 99) != 0);
      tick();
    end
    Reset = 1'b1;
    load = 1'b0;
    for (int t = 0; t < 2 * PERIOD; t++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_serial_stimulus_tx.md
Name: fsm_serial_stimulus_tx

Overview:
- Transmit end of the serial bit-stream interface consumed by the team's sequence-detector FSMs (single-bit `x_in` sampled every CLK).
- Accepts a parallel word through a ready/load handshake and shifts it out MSB-first on `x_out`, one bit per clock.
- Optional inter-word idle gap and framing strobes let a detector DUT be driven, and its `y_out` checked, in hardware rather than from a vector file.

Parameters:
- WIDTH, 8, data bits per word (legal range 2..32).
- GAP, 2, idle cycles (`x_out` = 0) inserted after each word (legal range 0..15).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load  input  1  request to send `data_in`; accepted only on a rising edge where `ready` = 1.
- data_in  input  WIDTH  word to serialize; sampled on the accepting edge only.
- ready  output  1  registered; 1 = block will accept `load` on the next edge.
- x_out  output  1  registered serial bit, MSB first; drives the detector's `x_in`.
- busy  output  1  registered; 1 while in SHIFT, PARITY or GAP.
- frame_start  output  1  registered; 1 during the cycle `x_out` carries bit WIDTH-1.
- done  output  1  registered; 1 during the cycle `x_out` carries the final bit of a frame.

Behaviour:
- Reset (Reset = 0, asynchronous): state = IDLE; shift register, bit counter and gap counter = 0.
  - Outputs: `ready` = 0, `x_out` = 0, `busy` = 0, `frame_start` = 0, `done` = 0.
  - `ready` rises at the first rising edge after Reset returns to 1.
- States: IDLE, SHIFT, PARITY (only with the optional feature), GAP.
- IDLE: `ready` = 1, `x_out` = 0.
  - On an edge with `load` = 1 and `ready` = 1: shreg <= `data_in`; `x_out` <= `data_in[WIDTH-1]`; `frame_start` <= 1; `ready` <= 0; `busy` <= 1; bitcnt <= WIDTH-1; next state SHIFT.
  - `load` = 0: remain in IDLE; all outputs hold.
- SHIFT: each edge shifts the next lower bit onto `x_out` and decrements bitcnt.
  - `frame_start` is 1 for exactly the first bit cycle.
  - `done` is 1 for exactly the cycle in which the last frame bit is on `x_out`.
  - Each bit is held on `x_out` for exactly one CLK period.
  - Latency: the first bit appears on the edge that accepts `load` (0 cycles from acceptance); the word occupies WIDTH consecutive cycles.
- After the last frame bit:
  - GAP > 0: state GAP; `x_out` <= 0; `busy` = 1 for GAP cycles.
  - GAP = 0: state IDLE directly.
- GAP: gapcnt counts GAP cycles, then state IDLE.
  - `ready` <= 1 on the same edge that enters IDLE, so the minimum word period is WIDTH + GAP + 1 cycles.
- `load` while `ready` = 0 is ignored and not queued; `data_in` changes while busy have no effect.
- Reset mid-frame aborts the frame immediately. `x_out` drops to 0 asynchronously; no partial-frame `done` is produced.
- `load` held high continuously: a new word is accepted on every edge where `ready` = 1. This gives back-to-back frames separated by GAP zeros plus one IDLE cycle.
- WIDTH = 1 or WIDTH > 32 is illegal; behaviour is undefined.

Optional Feature:
- Macro: SERIAL_PARITY_EN.
- Defined:
  - After bit 0, state PARITY drives one extra bit on `x_out` = XOR reduction of the accepted word (even parity).
  - `done` moves to the parity cycle; the frame is WIDTH+1 cycles; minimum word period is WIDTH + GAP + 2.
- Undefined:
  - No PARITY state exists; frame is WIDTH cycles; `done` is asserted on bit 0.

Test Plan:
- Reset release: hold Reset = 0 for 3 cycles, release -> all outputs 0 during reset; `ready` = 1 one edge after release; `x_out` stays 0.
- Single word: WIDTH = 8, GAP = 2, load `data_in` = 8'b1011_0010 -> `x_out` sequence 1,0,1,1,0,0,1,0 on 8 consecutive cycles, then 0,0.
  - `frame_start` high on the first bit only; `done` high on the 8th bit only.
  - `ready` = 0 for 10 cycles, then 1.
- Ignored load: pulse `load` with `data_in` = 8'hFF in the 3rd SHIFT cycle of word 8'h00 -> `x_out` stays all zeros; no second frame starts.
- Back-to-back: `load` held high with `data_in` = 8'hA5 -> frames repeat every 11 cycles (8 bits + 2 gap + 1 idle) and `x_out` pattern repeats.
  - Feed `x_out` into an FSM_a instance and check `y_out` against the detector's expected Mealy output per cycle.
- Reset mid-frame: assert Reset = 0 asynchronously at the 5th bit of 8'hC3 -> `x_out`, `busy` and `done` go to 0 without waiting for CLK.
  - After release, the next load of 8'h81 transmits cleanly from its MSB.
- SERIAL_PARITY_EN defined: load 8'b1011_0010 (four 1s) -> 9th bit = 0 with `done` on the 9th bit.
  - Load 8'b1011_0011 -> 9th bit = 1.
